// File: rtl/servo_seq_pkg.sv
// Shared types and default constants for the servo command sequencer.
// Build option: SERVO_SEQ_POS_CHECK_EN enables the position-tracking check.
package servo_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_FAULT
  } state_t;

  localparam int DEF_ANGLE_W     = 8;
  localparam int DEF_CUR_W       = 12;
  localparam int DEF_ANGLE_MAX   = 180;
  localparam int DEF_HOME_ANGLE  = 90;
  localparam int DEF_STEP_DEG    = 1;
  localparam int DEF_TICK_CYCLES = 50000;
  localparam int DEF_I_LIMIT     = 3000;
  localparam int DEF_OC_SAMPLES  = 16;
  localparam int DEF_COOLDOWN    = 500000;
  localparam int DEF_POS_TOL     = 5;
  localparam int DEF_POS_TIMEOUT = 100000;

endpackage

// File: rtl/servo_oc_monitor.sv
// Overcurrent filter: counts consecutive over-limit samples and
// emits a one-cycle trip pulse on the sample that reaches the limit.
module servo_oc_monitor
  import servo_seq_pkg::*;
#(
  parameter int CUR_W      = DEF_CUR_W,
  parameter int I_LIMIT    = DEF_I_LIMIT,
  parameter int OC_SAMPLES = DEF_OC_SAMPLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             meas_valid,
  input  logic [CUR_W-1:0] meas_current,
  output logic             trip
);

  localparam int CW = $clog2(OC_SAMPLES + 1);

  logic [CW-1:0] oc_cnt;
  logic          over;

  assign over = meas_current > CUR_W'(I_LIMIT);
  assign trip = meas_valid && over &&
                (oc_cnt == CW'(OC_SAMPLES - 1));

  // Saturating run-length of over-limit samples; a normal sample resets it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      oc_cnt <= '0;
    end else if (meas_valid) begin
      if (!over)
        oc_cnt <= '0;
      else if (oc_cnt != CW'(OC_SAMPLES))
        oc_cnt <= oc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: request arbitration, slew-limited setpoint,
// overcurrent supervision. Option: SERVO_SEQ_POS_CHECK_EN (pos_err).
module servo_cmd_sequencer
  import servo_seq_pkg::*;
#(
  parameter int ANGLE_W         = DEF_ANGLE_W,
  parameter int CUR_W           = DEF_CUR_W,
  parameter int ANGLE_MAX       = DEF_ANGLE_MAX,
  parameter int HOME_ANGLE      = DEF_HOME_ANGLE,
  parameter int STEP_DEG        = DEF_STEP_DEG,
  parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int I_LIMIT         = DEF_I_LIMIT,
  parameter int OC_SAMPLES      = DEF_OC_SAMPLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN,
  parameter int POS_TOL         = DEF_POS_TOL,
  parameter int POS_TIMEOUT     = DEF_POS_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [ANGLE_W-1:0] req_angle0,
  input  logic [ANGLE_W-1:0] req_angle1,
  output logic [1:0]         req_ready,
  input  logic               meas_valid,
  input  logic [CUR_W-1:0]   meas_current,
  input  logic [ANGLE_W-1:0] meas_angle,
  input  logic               fault_clr,
  output logic [ANGLE_W-1:0] setpoint,
  output logic               drive_en,
  output logic               busy,
  output logic               fault,
  output logic               pos_err
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int DW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] STEP = ANGLE_W'(STEP_DEG);

  state_t             state_q, state_d;
  logic [ANGLE_W-1:0] sp_q, sp_d, tgt_q, tgt_d;
  logic               drv_q, drv_d, busy_q, busy_d;
  logic               flt_q, flt_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [DW-1:0]      cool_q, cool_d;
  logic               trip, oc_clr, xfer;
  logic [ANGLE_W-1:0] raw, clamp, diff, step, sp_step;
  logic               up;

  servo_oc_monitor #(
    .CUR_W      (CUR_W),
    .I_LIMIT    (I_LIMIT),
    .OC_SAMPLES (OC_SAMPLES)
  ) u_oc (
    .clk          (clk),
    .rst          (rst),
    .clr          (oc_clr),
    .meas_valid   (meas_valid),
    .meas_current (meas_current),
    .trip         (trip)
  );

  assign req_ready = (state_q == ST_FAULT || trip) ? 2'b00
                   : {1'b1, !req_valid[1]};
  assign xfer  = |(req_valid & req_ready);
  assign raw   = req_valid[1] ? req_angle1 : req_angle0;
  assign clamp = (raw > AMAX) ? AMAX : raw;

  assign up      = tgt_q > sp_q;
  assign diff    = up ? tgt_q - sp_q : sp_q - tgt_q;
  assign step    = (diff < STEP) ? diff : STEP;
  assign sp_step = up ? sp_q + step : sp_q - step;

  // Next-state and next-output logic; a trip overrides everything.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    tgt_d   = tgt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    flt_d   = flt_q;
    tick_d  = tick_q;
    cool_d  = cool_q;
    oc_clr  = 1'b0;
    if (trip && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
      drv_d   = 1'b0;
      busy_d  = 1'b0;
      flt_d   = 1'b1;
      cool_d  = DW'(COOLDOWN_CYCLES);
    end else begin
      unique case (state_q)
        ST_FAULT: begin
          if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
          end else if (fault_clr) begin
            state_d = ST_IDLE;
            flt_d   = 1'b0;
            tgt_d   = sp_q;
            oc_clr  = 1'b1;
          end
        end
        ST_IDLE, ST_RAMP, ST_HOLD: begin
          if (xfer) begin
            tgt_d  = clamp;
            tick_d = '0;
            drv_d  = 1'b1;
            if (clamp == sp_q) begin
              state_d = ST_HOLD;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RAMP;
              busy_d  = 1'b1;
            end
          end else if (state_q == ST_RAMP) begin
            if (tick_q == TW'(TICK_CYCLES - 1)) begin
              tick_d = '0;
              sp_d   = sp_step;
              if (sp_step == tgt_q) begin
                state_d = ST_HOLD;
                busy_d  = 1'b0;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sp_q    <= ANGLE_W'(HOME_ANGLE);
      tgt_q   <= ANGLE_W'(HOME_ANGLE);
      drv_q   <= 1'b0;
      busy_q  <= 1'b0;
      flt_q   <= 1'b0;
      tick_q  <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      tgt_q   <= tgt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      flt_q   <= flt_d;
      tick_q  <= tick_d;
      cool_q  <= cool_d;
    end
  end

  assign setpoint = sp_q;
  assign drive_en = drv_q;
  assign busy     = busy_q;
  assign fault    = flt_q;

`ifdef SERVO_SEQ_POS_CHECK_EN
  localparam int PW = $clog2(POS_TIMEOUT + 1);

  logic [PW-1:0]      pos_cnt;
  logic               pos_q;
  logic [ANGLE_W-1:0] pdiff;
  logic               out_tol;

  assign pdiff   = (meas_angle > sp_q) ? meas_angle - sp_q
                 : sp_q - meas_angle;
  assign out_tol = pdiff > ANGLE_W'(POS_TOL);

  // Out-of-tolerance dwell counter in HOLD; pos_err is sticky.
  always_ff @(posedge clk) begin
    if (rst || oc_clr) begin
      pos_cnt <= '0;
      pos_q   <= 1'b0;
    end else if (state_q == ST_HOLD && out_tol) begin
      if (pos_cnt == PW'(POS_TIMEOUT - 1))
        pos_q <= 1'b1;
      if (pos_cnt != PW'(POS_TIMEOUT))
        pos_cnt <= pos_cnt + 1'b1;
    end else begin
      pos_cnt <= '0;
    end
  end

  assign pos_err = pos_q;
`else
  logic unused_pos;
  assign unused_pos = ^{meas_angle, 32'(POS_TOL), 32'(POS_TIMEOUT)};
  assign pos_err    = 1'b0;
`endif

endmodule

// File: doc/servo_cmd_sequencer.md
# servo_cmd_sequencer

Command sequencer for the servo datapath: arbitrates angle requests from two requesters, slew-limits the angle setpoint driven into the servo PWM block, and supervises measured current, forcing the drive off on a sustained overcurrent. Sits between the host/homing logic and `top_servo`. It owns `setpoint` and `drive_en`. The 50 MHz system clock (20 ns) is the only clock.

## Interface
Parameters:
- ANGLE_W, 8, angle width, integer degrees
- CUR_W, 12, current width, mA
- ANGLE_MAX, 180, upper clamp for any target
- HOME_ANGLE, 90, setpoint after reset
- STEP_DEG, 1, degrees moved per slew tick
- TICK_CYCLES, 50000, clocks per slew tick (1 ms)
- I_LIMIT, 3000, overcurrent threshold, mA (strictly greater trips)
- OC_SAMPLES, 16, consecutive over-limit samples to trip
- COOLDOWN_CYCLES, 500000, minimum fault dwell (10 ms)
- POS_TOL, 5, allowed |meas_angle - setpoint| (position check only)
- POS_TIMEOUT, 100000, cycles out of tolerance before pos_err (position check only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  request strobes; bit 1 = homing, bit 0 = host
- req_angle0  in  ANGLE_W  host target angle
- req_angle1  in  ANGLE_W  homing target angle
- req_ready  out  2  combinational grant; transfer on valid&ready
- meas_valid  in  1  one-cycle sample strobe for meas_current
- meas_current  in  CUR_W  measured motor current
- meas_angle  in  ANGLE_W  measured angle
- fault_clr  in  1  fault acknowledge
- setpoint  out  ANGLE_W  angle command to the servo
- drive_en  out  1  enables PWM output
- busy  out  1  high while in RAMP
- fault  out  1  high in FAULT
- pos_err  out  1  sticky position-tracking error

## Operation
- States: IDLE, RAMP, HOLD, FAULT.
- Reset (any state, mid-ramp included): state IDLE, setpoint=target=HOME_ANGLE, drive_en=0, busy=0, fault=0, pos_err=0, counters 0.
- Arbitration: req_ready is 0 in FAULT and in a cycle where a trip occurs. Otherwise bit 1 has fixed priority. req_ready[1]=1, and req_ready[0]=!req_valid[1].
- Accept (IDLE, RAMP or HOLD): target = min(req_angle, ANGLE_MAX). Tick counter cleared, drive_en=1, go to RAMP. Re-targeting mid-ramp continues from the current setpoint.
- Accept with clamped target == setpoint: go straight to HOLD, drive_en=1.
- RAMP: on each tick, setpoint moves toward target by min(STEP_DEG, |target-setpoint|). When they become equal: HOLD.
- Overcurrent: each meas_valid with meas_current > I_LIMIT increments oc_cnt. Any other sample clears it. When oc_cnt reaches OC_SAMPLES, trip to FAULT from any state.
- FAULT: drive_en=0, fault=1, setpoint frozen, cooldown counter loaded. Exit to IDLE only when the cooldown has expired and fault_clr=1. fault_clr during the cooldown is ignored, not latched.
- FAULT exit: target=setpoint, oc_cnt=0, drive_en stays 0 until the next accepted request.

## Timing
- Grant is same-cycle, combinational from registered state. All outputs are registered.
- Accept at edge N: RAMP and busy=1 at N+1. First setpoint step at N+TICK_CYCLES.
- Trip: the OC_SAMPLES-th over-limit sample at edge N gives fault=1 and drive_en=0 at N+1.
- Simultaneous trip and request: the trip wins and the request is not granted.
- Simultaneous fault_clr and expiry: exit is taken.
- Arithmetic is unsigned. The step is computed without underflow at 0 or overflow at ANGLE_MAX.

## Configuration
- SERVO_SEQ_POS_CHECK_EN defined: in HOLD, a counter runs while |meas_angle - setpoint| > POS_TOL and clears otherwise. At POS_TIMEOUT, pos_err sets and stays set until rst or a FAULT exit. It is informational only; no state change.
- Undefined: pos_err tied 0, the position-check counter is not built, and meas_angle is unused.

## Structure
- servo_seq_pkg holds the state enum typedef and the default parameter constants (HOME_ANGLE, I_LIMIT, etc.).
- Sub-module servo_oc_monitor contains the oc_cnt filter and produces a one-cycle trip pulse.

## Test plan
- Bench parameters: TICK_CYCLES=4, STEP_DEG=2, OC_SAMPLES=3, COOLDOWN_CYCLES=20.
- Reset, then host requests 100: setpoint 90→92→…→100, one step per 4 cycles. busy drops and HOLD is reached after 5 ticks.
- Both requesters valid (host 30, homing 150): only req_ready[1] is high. Target 150 and the ramp goes up. A host request of 200 then clamps to 180.
- Three consecutive samples of 3001 during a ramp: fault=1, drive_en=0 the next cycle, setpoint frozen. Samples 3001, 3000, 3001 do not trip.
- fault_clr at cooldown cycle 10 is ignored. fault_clr after cycle 20 gives IDLE with drive_en=0. A new request re-enables drive.
- rst asserted mid-ramp: all outputs return to reset values on the next edge.
- With SERVO_SEQ_POS_CHECK_EN, HOLD at 100 and meas_angle=90 for POS_TIMEOUT cycles: pos_err=1. meas_angle=96 never sets it.
